// File: rtl/crop_sequencer_if.sv
`default_nettype none
// ============================================================================
// crop_sequencer_if : pixel stream in/out bundle for the crop sequencer
// Revision: 1.0
// ============================================================================
interface crop_sequencer_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/crop_sequencer.sv
`default_nettype none
// ============================================================================
// crop_sequencer : per-image random resized-crop window controller
// Revision: 1.0
// ============================================================================
module crop_sequencer #(
    parameter int IMG_SIZE  = 28,
    parameter int CROP_STEP = 4,
    parameter int PIX_W     = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic [9:0]  rnd,
    output logic             rnd_step,
    crop_sequencer_if.slave  bus,
    output logic [1:0]       scale_o,
    output logic [4:0]       crop_size_o,
    output logic             busy,
    output logic             done
);

    localparam logic [4:0] c_LAST = 5'(IMG_SIZE - 1);
    localparam logic [4:0] c_SIZE = 5'(IMG_SIZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LATCH  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     r_state;
    logic [1:0] r_scale;
    logic [4:0] r_crop;
    logic [4:0] r_x_off;
    logic [4:0] r_y_off;
    logic [4:0] r_row;
    logic [4:0] r_col;
    logic       r_busy;
    logic       r_done;
    logic       r_rnd_step;

    logic [1:0] w_scale;
    logic [4:0] w_crop;
    logic [4:0] w_max_off;
    logic [4:0] w_x_raw;
    logic [4:0] w_y_raw;
    logic [4:0] w_row_end;
    logic [4:0] w_col_end;
    logic       w_stream;
    logic       w_inside;
    logic       w_hs;

    // Window geometry derived from the random word; only consumed in LATCH.
    assign w_scale   = rnd[1:0];
    assign w_crop    = 5'(IMG_SIZE - CROP_STEP * int'(w_scale));
    assign w_max_off = c_SIZE - w_crop;
    assign w_x_raw   = {1'b0, rnd[5:2]};
    assign w_y_raw   = {1'b0, rnd[9:6]};

    // Offset + crop never exceeds IMG_SIZE, so the window end fits in 5 bits.
    assign w_row_end = r_y_off + r_crop - 5'd1;
    assign w_col_end = r_x_off + r_crop - 5'd1;
    assign w_stream  = (r_state == S_STREAM);
    assign w_inside  = (r_row >= r_y_off) && (r_row <= w_row_end) &&
                       (r_col >= r_x_off) && (r_col <= w_col_end);

    // Inside pixels pass straight through; outside pixels are swallowed.
    assign bus.in_ready  = w_stream & (w_inside ? bus.out_ready : 1'b1);
    assign bus.out_valid = w_stream & w_inside & bus.in_valid;
    assign bus.out_data  = bus.in_data;
    assign bus.out_last  = bus.out_valid & (r_row == w_row_end) & (r_col == w_col_end);
    assign w_hs          = bus.in_valid & bus.in_ready;

    assign scale_o     = r_scale;
    assign crop_size_o = r_crop;
    assign busy        = r_busy;
    assign done        = r_done;
    assign rnd_step    = r_rnd_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_scale    <= 2'd0;
            r_crop     <= 5'd0;
            r_x_off    <= 5'd0;
            r_y_off    <= 5'd0;
            r_row      <= 5'd0;
            r_col      <= 5'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rnd_step <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done     <= 1'b0;
                    r_rnd_step <= 1'b0;
                    if (start) begin
                        r_state <= S_LATCH;
                        r_busy  <= 1'b1;
                    end
                end
                S_LATCH: begin
                    r_scale <= w_scale;
                    r_crop  <= w_crop;
                    r_x_off <= (w_x_raw > w_max_off) ? w_max_off : w_x_raw;
                    r_y_off <= (w_y_raw > w_max_off) ? w_max_off : w_y_raw;
                    r_row   <= 5'd0;
                    r_col   <= 5'd0;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        if (r_col == c_LAST) begin
                            r_col <= 5'd0;
                            if (r_row == c_LAST) begin
                                r_state    <= S_DONE;
                                r_done     <= 1'b1;
                                r_rnd_step <= 1'b1;
                            end else begin
                                r_row <= r_row + 5'd1;
                            end
                        end else begin
                            r_col <= r_col + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_done     <= 1'b0;
                    r_rnd_step <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/crop_sequencer.md
Name: crop_sequencer

Overview:
Per-image controller for the random resized-crop stage. On each image start it samples the 10-bit random word from the crop LFSR and derives a crop scale plus x/y offsets. It then streams one raster-order input image, forwards only the pixels inside the crop window to the rescaler, and pulses the LFSR step when the image is finished. It sits between the image-buffer read port and the rescale engine.

Parameters:
IMG_SIZE, 28, input image width and height in pixels (square image)
CROP_STEP, 4, crop edge shrink per scale step; crop_size = IMG_SIZE - CROP_STEP*scale
PIX_W, 8, pixel data width

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse; begin a new image
rnd  input  10  current crop LFSR word
rnd_step  output  1  one-cycle pulse; advance the LFSR
in_valid  input  1  input pixel valid
in_ready  output  1  input pixel accepted
in_data  input  PIX_W  input pixel
out_valid  output  1  cropped pixel valid
out_ready  input  1  downstream ready
out_data  output  PIX_W  cropped pixel
out_last  output  1  last pixel of the crop window
scale_o  output  2  latched scale for the rescaler
crop_size_o  output  5  latched crop edge length
busy  output  1  high from the LATCH state through the DONE state
done  output  1  one-cycle pulse at image end

Behaviour:
- Reset: FSM=IDLE; counters, scale_o, crop_size_o, offsets=0; rnd_step, done, busy, in_ready, out_valid, out_last=0. Reset mid-image aborts the image immediately. Partial image pixels are not flushed.
- FSM states: IDLE -> LATCH on start. LATCH -> STREAM after 1 cycle. STREAM -> DONE on handshake of input pixel (IMG_SIZE-1, IMG_SIZE-1). DONE -> IDLE after 1 cycle.
- start is ignored in any state other than IDLE.
- LATCH computes:
  - scale = rnd[1:0]; crop_size = IMG_SIZE - CROP_STEP*scale.
  - max_off = IMG_SIZE - crop_size.
  - x_off = min(rnd[5:2], max_off); y_off = min(rnd[9:6], max_off).
  - All values are unsigned and are registered at the end of LATCH.
- STREAM uses row/col counters (5 bits). col increments on each input handshake (in_valid & in_ready) and wraps at IMG_SIZE-1 to 0, incrementing row.
- inside = (row in [y_off, y_off+crop_size-1]) and (col in [x_off, x_off+crop_size-1]).
- Inside pixels: combinational pass-through with zero latency.
  - out_valid = in_valid; out_data = in_data; in_ready = out_ready.
- Outside pixels: in_ready=1 and out_valid=0. The pixel is consumed and dropped.
- out_last = out_valid while row = y_off+crop_size-1 and col = x_off+crop_size-1.
- Exactly crop_size^2 output handshakes occur per image.
- Outside STREAM: in_ready=0, out_valid=0.
- DONE: done=1 and rnd_step=1 for exactly one cycle. scale_o and crop_size_o hold until the next LATCH.
- rnd is sampled only in LATCH. Changes to rnd at other times have no effect.
- Backpressure: out_ready=0 on an inside pixel stalls the input. Counters hold and the FSM stays in STREAM.
- start in the same cycle as DONE is ignored. The next start is accepted from IDLE, at the earliest 1 cycle after done.

Test Plan:
1. rnd=10'b0000101001, start, continuous valid/ready -> scale_o=1, crop_size_o=24, x_off=4 (raw 10 clamped), y_off=0. 576 outputs; first output is input index 4, last output is index 23*28+27=671. out_last on output 576; done and rnd_step pulse 1 cycle after input 784.
2. rnd=10'b0101011011 -> scale_o=3, crop_size_o=16, y_off=5, x_off=6. 256 outputs; first output is input index 146, last is index 20*28+21=581.
3. rnd=10'b1111111100 -> scale 0, crop_size 28, offsets clamp to 0. All 784 pixels pass through unchanged; out_last on pixel 783.
4. Random out_ready (50%) with scale 2 -> exactly 400 outputs with in-order data. in_ready is low only on stalled inside pixels. No pixel is dropped or duplicated.
5. start pulses during STREAM, plus rnd changing mid-image -> no effect on the window or the counters; busy stays 1.
6. Assert reset at pixel 300 -> next cycle all outputs 0 and FSM in IDLE. A following start with a new rnd gives a full, correct image.
